// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ps2_pkg
// Description : Scan-code constants, receive FSM state encoding and the
//               per-player key map shared by the PS/2 front end.
//               Contents: KEY_* / PFX_* byte constants, RX_* states,
//               key_map_t and map_code().
// Revision    : 1.0 - initial release
// ============================================================================
package ps2_pkg;

  // Player-1 codes (also the values player 2 is remapped onto)
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] KEY_ENTER = 8'h5A;
  localparam logic [7:0] KEY_ESC   = 8'h76;
  localparam logic [7:0] KEY_SPACE = 8'h29;

  // Player-2 raw codes
  localparam logic [7:0] KEY_W = 8'h1D;
  localparam logic [7:0] KEY_S = 8'h1B;
  localparam logic [7:0] KEY_A = 8'h1C;
  localparam logic [7:0] KEY_D = 8'h23;
  localparam logic [7:0] KEY_F = 8'h2B;

  // Prefix bytes
  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  // Receive FSM states
  localparam logic [1:0] RX_IDLE   = 2'd0;
  localparam logic [1:0] RX_DATA   = 2'd1;
  localparam logic [1:0] RX_PARITY = 2'd2;
  localparam logic [1:0] RX_STOP   = 2'd3;

  typedef struct packed {
    logic       hit_1;  // code belongs to player 1
    logic       hit_2;  // code belongs to player 2
    logic [7:0] code;   // value to present on the player's output
  } key_map_t;

  // Resolve a code byte against the extended-prefix flag.
  function automatic key_map_t map_code(input logic [7:0] raw, input logic ext);
    key_map_t m;
    m = '0;
    if (ext) begin
      if (raw == KEY_UP || raw == KEY_DOWN || raw == KEY_LEFT || raw == KEY_RIGHT) begin
        m.hit_1 = 1'b1;
        m.code  = raw;
      end
    end else begin
      case (raw)
        KEY_ENTER, KEY_ESC, KEY_SPACE: begin m.hit_1 = 1'b1; m.code = raw;       end
        KEY_W:                         begin m.hit_2 = 1'b1; m.code = KEY_UP;    end
        KEY_S:                         begin m.hit_2 = 1'b1; m.code = KEY_DOWN;  end
        KEY_A:                         begin m.hit_2 = 1'b1; m.code = KEY_LEFT;  end
        KEY_D:                         begin m.hit_2 = 1'b1; m.code = KEY_RIGHT; end
        KEY_F:                         begin m.hit_2 = 1'b1; m.code = KEY_SPACE; end
        default:                       m = '0;
      endcase
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
// Module      : ps2_rx
// Description : PS/2 frame receiver: line synchronizers, falling-edge
//               detect, start/data/parity/stop FSM and inactivity timeout.
//   i_clk, i_rst   system clock, async active-high reset
//   i_ps2_clk/dat  raw PS/2 lines (asynchronous, idle high)
//   o_byte         received byte (valid while o_valid is high)
//   o_valid        one-cycle pulse, good frame
//   o_err          one-cycle pulse, parity/stop/timeout error
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_byte,
  output logic       o_valid,
  output logic       o_err
);

  localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
  logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
  logic                   clk_prev_q, clk_prev_d;
  logic                   fall_q, fall_d;
  logic [1:0]             state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [7:0]             shift_q, shift_d;
  logic                   parity_q, parity_d;
  logic [TMO_W-1:0]       tmo_q, tmo_d;
  logic                   dat_bit;

  assign dat_bit = dat_sync_q[SYNC_STAGES-1];
  assign o_byte  = shift_q;

  always_comb begin
    clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], i_ps2_clk};
    dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], i_ps2_dat};
    clk_prev_d = clk_sync_q[SYNC_STAGES-1];
    fall_d     = clk_prev_q & ~clk_sync_q[SYNC_STAGES-1];

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tmo_d     = tmo_q;
    o_valid   = 1'b0;
    o_err     = 1'b0;

    if (fall_q) begin
      tmo_d = '0;
      case (state_q)
        RX_IDLE: begin
          if (!dat_bit) begin
            state_d   = RX_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        RX_DATA: begin
          shift_d   = {dat_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
        end
        RX_PARITY: begin
          parity_d = dat_bit;
          state_d  = RX_STOP;
        end
        default: begin  // RX_STOP
          state_d = RX_IDLE;
          // Odd parity: XOR over data plus parity bit must be 1.
          if (dat_bit && (^{shift_q, parity_q})) o_valid = 1'b1;
          else                                   o_err   = 1'b1;
        end
      endcase
    end else if (state_q != RX_IDLE) begin
      if (tmo_q >= TMO_LAST) begin
        state_d = RX_IDLE;
        tmo_d   = '0;
        o_err   = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end else begin
      tmo_d = '0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      clk_sync_q <= '1;
      dat_sync_q <= '1;
      clk_prev_q <= 1'b1;
      fall_q     <= 1'b0;
      state_q    <= RX_IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      parity_q   <= 1'b0;
      tmo_q      <= '0;
    end else begin
      clk_sync_q <= clk_sync_d;
      dat_sync_q <= dat_sync_d;
      clk_prev_q <= clk_prev_d;
      fall_q     <= fall_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tmo_q      <= tmo_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ps2_key_router.sv
`default_nettype none
// ============================================================================
// Module      : ps2_key_router
// Description : Keyboard front end for two players. Decodes E0/F0 prefixes,
//               maps codes to a player and keeps one held-key register each.
//   i_clk, i_rst          system clock, async active-high reset
//   i_ps2_clk, i_ps2_dat  raw PS/2 lines
//   o_key_1, o_key_2      held key per player, 8'h00 when none
//   o_press_1, o_press_2  one-cycle pulse on a new non-zero key value
//   o_frame_err           one-cycle pulse on a rejected/abandoned frame
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_key_router
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_ps2_clk,
  input  logic       i_ps2_dat,
  output logic [7:0] o_key_1,
  output logic [7:0] o_key_2,
  output logic       o_press_1,
  output logic       o_press_2,
  output logic       o_frame_err
);

  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       rx_err;
  key_map_t   map;

  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [7:0] key_1_q, key_1_d;
  logic [7:0] key_2_q, key_2_d;
  logic       press_1_q, press_1_d;
  logic       press_2_q, press_2_d;
  logic       err_q, err_d;

  ps2_rx #(
    .SYNC_STAGES (SYNC_STAGES),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_rx (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_ps2_clk (i_ps2_clk),
    .i_ps2_dat (i_ps2_dat),
    .o_byte    (rx_byte),
    .o_valid   (rx_valid),
    .o_err     (rx_err)
  );

  assign map = map_code(rx_byte, ext_q);

  always_comb begin
    ext_d     = ext_q;
    brk_d     = brk_q;
    key_1_d   = key_1_q;
    key_2_d   = key_2_q;
    press_1_d = 1'b0;
    press_2_d = 1'b0;
    err_d     = rx_err;

    if (rx_err) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (rx_valid) begin
      if (rx_byte == PFX_EXT) begin
        ext_d = 1'b1;
      end else if (rx_byte == PFX_BRK) begin
        brk_d = 1'b1;
      end else begin
        ext_d = 1'b0;
        brk_d = 1'b0;
        // A break only releases the key currently shown, so releasing an
        // older superseded key leaves the newer one held.
        if (map.hit_1) begin
          if (brk_q) begin
            if (key_1_q == map.code) key_1_d = 8'h00;
          end else begin
            key_1_d   = map.code;
            press_1_d = (key_1_q != map.code);
          end
        end
        if (map.hit_2) begin
          if (brk_q) begin
            if (key_2_q == map.code) key_2_d = 8'h00;
          end else begin
            key_2_d   = map.code;
            press_2_d = (key_2_q != map.code);
          end
        end
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ext_q     <= 1'b0;
      brk_q     <= 1'b0;
      key_1_q   <= 8'h00;
      key_2_q   <= 8'h00;
      press_1_q <= 1'b0;
      press_2_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      ext_q     <= ext_d;
      brk_q     <= brk_d;
      key_1_q   <= key_1_d;
      key_2_q   <= key_2_d;
      press_1_q <= press_1_d;
      press_2_q <= press_2_d;
      err_q     <= err_d;
    end
  end

  assign o_key_1     = key_1_q;
  assign o_key_2     = key_2_q;
  assign o_press_1   = press_1_q;
  assign o_press_2   = press_2_q;
  assign o_frame_err = err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_router.sv
`default_nettype none
// ============================================================================
// Module      : tb_ps2_key_router
// Description : Self-checking bench for ps2_key_router. A table of PS/2
//               bytes with expected held keys and pulse counts, plus
//               hand-written latency, timeout and reset sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ps2_key_router;

  localparam int SYNC = 2;
  localparam int TMO  = 200;
  localparam int HALF = 20;   // PS/2 half bit period in system clocks
  localparam int GAP  = 30;   // idle clocks between frames

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] key_1, key_2;
  logic       press_1, press_2, frame_err;

  int n_cmp = 0;
  int n_bad = 0;
  int c_p1 = 0, c_p2 = 0, c_err = 0;

  always #5 clk = ~clk;

  ps2_key_router #(.SYNC_STAGES(SYNC), .TIMEOUT_CYC(TMO)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ps2_clk   (ps2_clk),
    .i_ps2_dat   (ps2_dat),
    .o_key_1     (key_1),
    .o_key_2     (key_2),
    .o_press_1   (press_1),
    .o_press_2   (press_2),
    .o_frame_err (frame_err)
  );

  always @(negedge clk) begin
    if (press_1)   c_p1  = c_p1 + 1;
    if (press_2)   c_p2  = c_p2 + 1;
    if (frame_err) c_err = c_err + 1;
  end

  // kind: 0 good frame, 1 bad parity, 2 stop bit = 0
  typedef struct {
    logic [7:0] b;
    int         kind;
    logic [7:0] k1;
    logic [7:0] k2;
    int         p1;
    int         p2;
    int         er;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_counts();
    c_p1  = 0;
    c_p2  = 0;
    c_err = 0;
  endtask

  // Drive the first nbits bits of a frame (start, 8 data LSB first, parity, stop).
  task automatic send_bits(input logic [7:0] b, input logic par, input logic stp, input int nbits);
    logic [10:0] f;
    f = {stp, par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = f[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input int kind);
    logic par;
    par = (kind == 1) ? (^b) : ~(^b);
    send_bits(b, par, (kind != 2), 11);
    repeat (GAP) @(negedge clk);
  endtask

  task automatic add(input logic [7:0] b, input int kind, input logic [7:0] k1,
                     input logic [7:0] k2, input int p1, input int p2, input int er);
    vec_t v;
    v.b = b; v.kind = kind; v.k1 = k1; v.k2 = k2; v.p1 = p1; v.p2 = p2; v.er = er;
    vecs.push_back(v);
  endtask

  initial begin
    // byte  kind key1   key2   p1 p2 err
    add(8'hE0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'h75, 0, 8'h75, 8'h00, 1, 0, 0);  // ext up -> player 1
    add(8'hE0, 0, 8'h75, 8'h00, 0, 0, 0);
    add(8'hF0, 0, 8'h75, 8'h00, 0, 0, 0);
    add(8'h75, 0, 8'h00, 8'h00, 0, 0, 0);  // release up
    add(8'h1D, 0, 8'h00, 8'h75, 0, 1, 0);  // W -> up on player 2
    add(8'h1D, 0, 8'h00, 8'h75, 0, 0, 0);  // typematic repeats
    add(8'h1D, 0, 8'h00, 8'h75, 0, 0, 0);
    add(8'h1D, 0, 8'h00, 8'h75, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 8'h75, 0, 0, 0);
    add(8'h1D, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'h5A, 0, 8'h5A, 8'h00, 1, 0, 0);
    add(8'h76, 0, 8'h76, 8'h00, 1, 0, 0);
    add(8'hF0, 0, 8'h76, 8'h00, 0, 0, 0);
    add(8'h5A, 0, 8'h76, 8'h00, 0, 0, 0);  // superseded key release ignored
    add(8'hF0, 0, 8'h76, 8'h00, 0, 0, 0);
    add(8'h76, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'h29, 0, 8'h29, 8'h00, 1, 0, 0);
    add(8'h5A, 1, 8'h29, 8'h00, 0, 0, 1);  // bad parity
    add(8'h5A, 2, 8'h29, 8'h00, 0, 0, 1);  // bad stop
    add(8'hF0, 0, 8'h29, 8'h00, 0, 0, 0);
    add(8'h29, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'hF0, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'h5A, 1, 8'h00, 8'h00, 0, 0, 1);  // error clears break flag
    add(8'h5A, 0, 8'h5A, 8'h00, 1, 0, 0);  // so this is a make
    add(8'h1D, 0, 8'h5A, 8'h75, 0, 1, 0);  // players independent
    add(8'hE0, 0, 8'h5A, 8'h75, 0, 0, 0);
    add(8'h1D, 0, 8'h5A, 8'h75, 0, 0, 0);  // ext non-arrow ignored
    add(8'h6B, 0, 8'h5A, 8'h75, 0, 0, 0);  // non-ext 6B ignored
    add(8'hE0, 0, 8'h5A, 8'h75, 0, 0, 0);
    add(8'h6B, 0, 8'h6B, 8'h75, 1, 0, 0);  // ext left
    add(8'hE0, 0, 8'h6B, 8'h75, 0, 0, 0);
    add(8'hE0, 0, 8'h6B, 8'h75, 0, 0, 0);
    add(8'hF0, 0, 8'h6B, 8'h75, 0, 0, 0);
    add(8'hF0, 0, 8'h6B, 8'h75, 0, 0, 0);
    add(8'h6B, 0, 8'h00, 8'h75, 0, 0, 0);  // doubled prefixes still break
    add(8'hF0, 0, 8'h00, 8'h75, 0, 0, 0);
    add(8'h1D, 0, 8'h00, 8'h00, 0, 0, 0);
    add(8'h2B, 0, 8'h00, 8'h29, 0, 1, 0);  // F -> space on player 2
    add(8'hF0, 0, 8'h00, 8'h29, 0, 0, 0);
    add(8'h2B, 0, 8'h00, 8'h00, 0, 0, 0);

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_key_1", {24'h0, key_1}, 32'h00);
    chk("rst_key_2", {24'h0, key_2}, 32'h00);
    chk("rst_press_1", {31'h0, press_1}, 32'h0);
    chk("rst_press_2", {31'h0, press_2}, 32'h0);
    chk("rst_frame_err", {31'h0, frame_err}, 32'h0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    foreach (vecs[i]) begin
      clr_counts();
      send_frame(vecs[i].b, vecs[i].kind);
      chk($sformatf("v%0d_key_1", i), {24'h0, key_1}, {24'h0, vecs[i].k1});
      chk($sformatf("v%0d_key_2", i), {24'h0, key_2}, {24'h0, vecs[i].k2});
      chk($sformatf("v%0d_press_1", i), c_p1, vecs[i].p1);
      chk($sformatf("v%0d_press_2", i), c_p2, vecs[i].p2);
      chk($sformatf("v%0d_frame_err", i), c_err, vecs[i].er);
    end

    // Latency: outputs update exactly SYNC+2 clocks after the stop-bit fall.
    clr_counts();
    send_bits(8'h5A, ~(^8'h5A), 1'b1, 10);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (SYNC + 1) @(negedge clk);
    chk("lat_key_1_before", {24'h0, key_1}, 32'h00);
    @(negedge clk);
    chk("lat_key_1_after", {24'h0, key_1}, 32'h5A);
    chk("lat_press_1", {31'h0, press_1}, 32'h1);
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (GAP) @(negedge clk);
    chk("lat_press_1_count", c_p1, 1);
    send_frame(8'hF0, 0);
    send_frame(8'h5A, 0);
    chk("lat_release", {24'h0, key_1}, 32'h00);

    // Timeout: abandon a frame after 4 data bits.
    clr_counts();
    send_bits(8'h29, ~(^8'h29), 1'b1, 5);
    repeat (TMO + 50) @(negedge clk);
    chk("tmo_frame_err", c_err, 1);
    chk("tmo_key_1", {24'h0, key_1}, 32'h00);
    send_frame(8'h29, 0);
    chk("tmo_next_key_1", {24'h0, key_1}, 32'h29);
    chk("tmo_next_err", c_err, 1);

    // Reset after a break prefix: next code is a fresh make.
    send_frame(8'hF0, 0);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_key_1", {24'h0, key_1}, 32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    clr_counts();
    send_frame(8'h1B, 0);
    chk("post_rst_key_2", {24'h0, key_2}, 32'h72);
    chk("post_rst_press_2", c_p2, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
